out_capture_fifo: RTL and testbench

//  Downstream capture stage for the top-level logic outputs (out1..out5).

---
 rtl/out_capture_pkg.sv | 22 ++
 rtl/out_capture_mem.sv | 35 +++
 rtl/out_capture_fifo.sv | 137 +++++++++++++
 tb/tb_out_capture_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/out_capture_pkg.sv
// Package: out_capture_pkg
// Purpose: shared defaults for the output-capture FIFO slice and a helper
//          for sizing the FIFO pointers.
// Contents:
//   DEF_WIDTH  captured vector width ({out5..out1})
//   DEF_DEPTH  FIFO entries (power of 2, >= 2)
//   DEF_TS_W   timestamp counter width
//   DEF_OVF_W  overflow counter width
//   ptr_width  pointer width for a given depth (one extra wrap bit)
package out_capture_pkg;

  localparam int unsigned DEF_WIDTH = 5;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_TS_W  = 8;
  localparam int unsigned DEF_OVF_W = 8;

  // The extra MSB lets full and empty be told apart when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_capture_mem.sv
// Module: out_capture_mem
// Purpose: DEPTH x DW flop array backing the capture FIFO. One synchronous
//          write port and one asynchronous read port. The array has no reset;
//          validity of entries is tracked by the FIFO pointers.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
module out_capture_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 13,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_capture_fifo.sv
// Module: out_capture_fifo
// Purpose: capture stage for the top-level logic outputs. Registers the
//          output vector, optionally keeps only changed values, timestamps
//          each accepted sample and buffers it in a small first-word
//          fall-through FIFO drained through a valid/ready port.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   sample_en     in   sample din this cycle
//   change_only   in   push only values that differ from the last pushed one
//   din           in   [WIDTH]   upstream output vector
//   m_valid       out  head entry available
//   m_ready       in   consumer accepts head entry
//   m_data        out  [WIDTH]   head entry data (holds last value when empty)
//   m_stamp       out  [TS_W]    head entry timestamp (holds when empty)
//   level         out  [log2(DEPTH)+1] entries stored
//   full          out  level == DEPTH
//   overflow_cnt  out  [OVF_W]   dropped samples, saturating
module out_capture_fifo
  import out_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned OVF_W = DEF_OVF_W,
  localparam int unsigned PW   = ptr_width(DEPTH),
  localparam int unsigned AW   = PW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             change_only,
  input  logic [WIDTH-1:0] din,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [TS_W-1:0]  m_stamp,
  output logic [PW-1:0]    level,
  output logic             full,
  output logic [OVF_W-1:0] overflow_cnt
);

  localparam int unsigned DW = WIDTH + TS_W;

  logic [TS_W-1:0]  ts_cnt;
  logic             cap_v;
  logic [WIDTH-1:0] cap_d;
  logic [TS_W-1:0]  cap_ts;
  logic [WIDTH-1:0] last_d;
  logic             first_flag;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold_data;
  logic [TS_W-1:0]  hold_stamp;
  logic [DW-1:0]    rd_word;
  logic             empty;
  logic             pop;
  logic             push_req;
  logic             wr_en;
  logic             drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign m_valid  = !empty;
  assign pop      = !empty && m_ready;

  // The first sample after reset always passes the change filter.
  assign push_req = cap_v && (!change_only || first_flag || (cap_d != last_d));
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en    = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Empty FIFO shows the last popped entry instead of stale array contents.
  assign m_data   = empty ? hold_data  : rd_word[WIDTH-1:0];
  assign m_stamp  = empty ? hold_stamp : rd_word[DW-1:WIDTH];

  out_capture_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({cap_ts, cap_d}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      cap_v  <= 1'b0;
      cap_d  <= '0;
      cap_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      cap_v  <= sample_en;
      cap_d  <= din;
      cap_ts <= ts_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d     <= '0;
      first_flag <= 1'b1;
      wr_ptr     <= '0;
    end else if (wr_en) begin
      last_d     <= cap_d;
      first_flag <= 1'b0;
      wr_ptr     <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      hold_data  <= '0;
      hold_stamp <= '0;
    end else if (pop) begin
      rd_ptr     <= rd_ptr + PW'(1);
      hold_data  <= rd_word[WIDTH-1:0];
      hold_stamp <= rd_word[DW-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != '1)) begin
      overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_out_capture_fifo.sv
// Testbench: tb_out_capture_fifo
// Purpose: directed checks of out_capture_fifo (DEPTH=4, OVF_W=2): reset
//          state, capture latency and timestamp, change filtering, overflow
//          and saturation, full-with-pop throughput and mid-stream reset.
module tb_out_capture_fifo;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic       change_only;
  logic [4:0] din;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] m_data;
  logic [7:0] m_stamp;
  logic [2:0] level;
  logic       full;
  logic [1:0] overflow_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int edge_count  = 0;
  logic [7:0] cap_stamp;
  logic [7:0] stamp3 [4];
  logic [4:0] exp_head;

  out_capture_fifo #(
    .WIDTH (5),
    .DEPTH (4),
    .TS_W  (8),
    .OVF_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .change_only  (change_only),
    .din          (din),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_stamp      (m_stamp),
    .level        (level),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs; cap_stamp is the timestamp the DUT captures.
  task automatic applyStimulus(input logic se, input logic co, input logic [4:0] d,
                               input logic rdy);
    sample_en   = se;
    change_only = co;
    din         = d;
    m_ready     = rdy;
    cap_stamp   = edge_count[7:0];
    @(posedge clk);
    edge_count++;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    change_only = 1'b0;
    din = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ovf", overflow_cnt, 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_stamp", m_stamp, 0);
    rst = 1'b0;
    edge_count = 0;

    $display("[TB] test 1: single sample latency");
    applyStimulus(0, 0, 5'h00, 0);
    applyStimulus(1, 0, 5'h15, 0);
    checkOutput("t1_valid_early", m_valid, 0);
    applyStimulus(0, 0, 5'h00, 0);
    checkOutput("t1_valid", m_valid, 1);
    checkOutput("t1_data", m_data, 5'h15);
    checkOutput("t1_stamp", m_stamp, 8'h01);
    checkOutput("t1_level", level, 1);
    applyStimulus(0, 0, 5'h00, 1);
    checkOutput("t1_pop_valid", m_valid, 0);
    checkOutput("t1_hold_data", m_data, 5'h15);

    $display("[TB] test 2: change filter");
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 5'h0A, 0);
    applyStimulus(1, 1, 5'h0B, 0);
    applyStimulus(0, 1, 5'h00, 0);
    applyStimulus(0, 1, 5'h00, 0);
    checkOutput("t2_level", level, 2);
    checkOutput("t2_head0", m_data, 5'h0A);
    applyStimulus(0, 1, 5'h00, 1);
    checkOutput("t2_head1", m_data, 5'h0B);
    applyStimulus(0, 1, 5'h00, 1);
    checkOutput("t2_empty", level, 0);

    $display("[TB] test 3: overflow");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 5'(i + 1), 0);
      if (i < 4) stamp3[i] = cap_stamp;
      if (i == 4) checkOutput("t3_full", full, 1);
    end
    applyStimulus(0, 0, 5'h00, 0);
    applyStimulus(0, 0, 5'h00, 0);
    checkOutput("t3_ovf", overflow_cnt, 2);
    checkOutput("t3_level", level, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_drain_data", m_data, 32'(i + 1));
      checkOutput("t3_drain_stamp", m_stamp, stamp3[i]);
      applyStimulus(0, 0, 5'h00, 1);
    end
    checkOutput("t3_drained", level, 0);

    $display("[TB] test 4: full with simultaneous pop");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 5'(8'h11 + i), 0);
    checkOutput("t4_full", full, 1);
    for (int j = 1; j <= 10; j++) begin
      exp_head = 5'(8'h10 + j);
      checkOutput("t4_level", level, 4);
      checkOutput("t4_head", m_data, exp_head);
      applyStimulus(1, 0, 5'(8'h15 + j), 1);
    end
    applyStimulus(0, 0, 5'h00, 1);
    checkOutput("t4_level_end", level, 4);
    checkOutput("t4_ovf", overflow_cnt, 2);
    checkOutput("t4_head_end", m_data, 5'h1C);

    $display("[TB] test 5: overflow saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 5'(i + 1), 0);
      if (i == 1) checkOutput("t5_ovf_first", overflow_cnt, 3);
    end
    applyStimulus(0, 0, 5'h00, 0);
    checkOutput("t5_ovf_sat", overflow_cnt, 3);
    checkOutput("t5_head", m_data, 5'h1C);

    $display("[TB] test 6: mid-stream reset");
    applyStimulus(0, 0, 5'h00, 1);
    checkOutput("t6_level_pre", level, 3);
    rst = 1'b1;
    #2;
    checkOutput("t6_valid", m_valid, 0);
    checkOutput("t6_level", level, 0);
    checkOutput("t6_ovf", overflow_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_count = 0;
    applyStimulus(1, 1, 5'h1F, 0);
    applyStimulus(0, 1, 5'h00, 0);
    applyStimulus(0, 1, 5'h00, 0);
    checkOutput("t6_first_push", level, 1);
    checkOutput("t6_data", m_data, 5'h1F);
    checkOutput("t6_stamp", m_stamp, 8'h00);
    applyStimulus(1, 1, 5'h1F, 0);
    applyStimulus(0, 1, 5'h00, 0);
    applyStimulus(0, 1, 5'h00, 0);
    checkOutput("t6_repeat_dropped", level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
